sd_slv_cmd_dec: RTL and testbench
=================================

Name: sd_slv_cmd_dec

Overview:
SD slave command-line receiver/decoder sitting directly upstream of the slave memory read path. Deserialises 48-bit host command frames from the CMD line and checks the start, direction, CRC7 and end bits. Decodes CMD0, CMD16, CMD55, ACMD6 and CMD17. Produces the read-path controls `bus_width`, `read`, `ldad` and `adln`, plus status strobes for the response generator.

Parameters:
- BLEN_DEF, 512: block length loaded into adln on reset and on CMD0.
- AW, 10: width of ldad and adln.

Ports:
- clk  in  1  card clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_i  in  1  sampled CMD line; idle high.
- busy  in  1  read path active (memory output enable); high blocks a new read.
- bus_width  out  2  00 = 1-bit DAT, 10 = 4-bit DAT.
- read  out  1  one-cycle read start pulse (CMD17 accepted).
- ldad  out  AW  start address latched from CMD17 arg[AW-1:0].
- adln  out  AW  read length in bytes (CMD16).
- cmd_idx  out  6  index of last received frame.
- cmd_arg  out  32  argument of last received frame.
- cmd_vld  out  1  one-cycle pulse: good frame received.
- crc_err  out  1  one-cycle pulse: CRC7 or end-bit failure.
- cmd_ill  out  1  one-cycle pulse: good frame but illegal or unsupported command or argument.

Behaviour:
Reset values (rst low, asynchronous):
- bus_width = 00, read = 0, ldad = 0, adln = BLEN_DEF, cmd_idx = 0, cmd_arg = 0.
- All pulses 0, app flag 0, FSM in IDLE.

Frame format, MSB first: start 0, dir 1, idx[5:0], arg[31:0], crc7[6:0], end 1.

FSM states:
- IDLE: on cmd_i = 0, go to DIR and clear the CRC7.
- DIR: cmd_i = 1 goes to BODY. cmd_i = 0 returns to IDLE silently (card-originated or glitch).
- BODY: 38-bit counter shifts idx and arg. After bit 38, go to CRC.
- CRC: compare 7 received bits against the computed CRC7, then go to END.
- END:
  - cmd_i = 1 and CRC matches: assert decode and return to IDLE.
  - Otherwise: pulse crc_err and return to IDLE; no state change.

CRC7 rules:
- Polynomial x^7 + x^3 + 1, register initialised to 0.
- Fed the 40 bits start..arg[0].

Decode, registered with outputs valid the cycle after the end bit is sampled:
- cmd_vld pulses for every good frame; cmd_idx and cmd_arg are updated on the same edge.
- CMD0: bus_width = 00, adln = BLEN_DEF, app flag cleared.
- CMD55: app flag set.
- ACMD6 (idx 6 with app flag set):
  - arg[1:0] = 00 sets bus_width = 00; 10 sets bus_width = 10.
  - 01 or 11 leaves bus_width unchanged and pulses cmd_ill.
- CMD6 without app flag: cmd_ill.
- CMD16:
  - arg in 1..2^AW-1 loads adln = arg[AW-1:0].
  - arg = 0 or arg >= 2^AW keeps adln unchanged and pulses cmd_ill.
- CMD17:
  - busy = 0: ldad = arg[AW-1:0], read = 1 for exactly one cycle, concurrent with cmd_vld.
  - busy = 1: no read, ldad unchanged, cmd_ill.
- Any other idx: cmd_vld only, no side effects.
- App flag is cleared by any good frame other than CMD55 (including ACMD6). It is not touched by a crc_err frame.

Boundaries:
- Back-to-back frames: IDLE accepts a start bit the cycle after END, so no gap is required.
- Start bit detection holds off until END completes; a 0 seen during BODY is data.
- Reset mid-frame aborts immediately; no pulses are emitted.
- read, cmd_vld, crc_err and cmd_ill never assert while in reset.
- crc_err and cmd_vld are mutually exclusive.
- cmd_ill is always accompanied by cmd_vld.

Test Plan:
1. Reset, then CMD0 arg 0 with crc7 0x4A. Required: cmd_vld = 1, cmd_idx = 0, adln = 512, bus_width = 00, no crc_err.
2. CMD16 arg 0x40, then CMD17 arg 0x123, with busy = 0 and bench-model CRCs. Required: adln = 0x040; a single read pulse coincident with cmd_vld; ldad = 0x123.
3. CMD55 then ACMD6 arg 0x2. Required: bus_width = 10. A following bare CMD6 arg 0x0 gives cmd_ill = 1 and bus_width stays 10.
4. CMD17 with one flipped CRC bit, and separately a frame with end bit 0. Required: crc_err pulses, no cmd_vld, no read, ldad unchanged.
5. CMD17 arg 0x010 with busy = 1. Required: cmd_vld = 1, cmd_ill = 1, read stays 0. CMD16 arg 0 and arg 0x400 each give cmd_ill with adln unchanged.
6. Drop rst after 20 bits of a CMD17, release, then send a clean CMD17 arg 0x3FF. Required: no pulses from the aborted frame; ldad = 0x3FF with one read pulse.

Source files
------------

// File: rtl/sd_slv_cmd_dec.sv
// SD slave CMD-line receiver: deserialises 48-bit host frames, checks CRC7/end bit,
// decodes CMD0/6/16/17/55 into read-path controls and response-generator strobes.
module sd_slv_cmd_dec #(
  parameter int BLEN_DEF = 512,
  parameter int AW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_i,
  input  logic          busy,
  output logic [1:0]    bus_width,
  output logic          read,
  output logic [AW-1:0] ldad,
  output logic [AW-1:0] adln,
  output logic [5:0]    cmd_idx,
  output logic [31:0]   cmd_arg,
  output logic          cmd_vld,
  output logic          crc_err,
  output logic          cmd_ill
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DIR    = 3'd1;
  localparam logic [2:0] BODY   = 3'd2;
  localparam logic [2:0] CRC    = 3'd3;
  localparam logic [2:0] ST_END = 3'd4;

  logic [2:0]  state;
  logic [5:0]  cnt;
  logic [37:0] sh;
  logic [6:0]  crc, crc_nxt, rx_crc;
  logic        app;
  logic        fb;
  logic [5:0]  f_idx;
  logic [31:0] f_arg;
  logic        len_ok;

  // CRC7, x^7 + x^3 + 1, serial form
  assign fb      = cmd_i ^ crc[6];
  assign crc_nxt = {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};

  assign f_idx  = sh[37:32];
  assign f_arg  = sh[31:0];
  assign len_ok = (f_arg != 32'd0) && (f_arg[31:AW] == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      crc       <= '0;
      rx_crc    <= '0;
      app       <= 1'b0;
      bus_width <= 2'b00;
      read      <= 1'b0;
      ldad      <= '0;
      adln      <= AW'(BLEN_DEF);
      cmd_idx   <= '0;
      cmd_arg   <= '0;
      cmd_vld   <= 1'b0;
      crc_err   <= 1'b0;
      cmd_ill   <= 1'b0;
    end else begin
      read    <= 1'b0;
      cmd_vld <= 1'b0;
      crc_err <= 1'b0;
      cmd_ill <= 1'b0;
      case (state)
        // start bit 0 into a zero CRC leaves it zero, so clearing covers it
        IDLE: if (!cmd_i) begin
          state <= DIR;
          crc   <= '0;
        end
        DIR: if (cmd_i) begin
          state <= BODY;
          crc   <= crc_nxt;
          cnt   <= '0;
        end else begin
          state <= IDLE;
        end
        BODY: begin
          sh  <= {sh[36:0], cmd_i};
          crc <= crc_nxt;
          if (cnt == 6'd37) begin
            cnt   <= '0;
            state <= CRC;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        CRC: begin
          rx_crc <= {rx_crc[5:0], cmd_i};
          if (cnt == 6'd6) state <= ST_END;
          else             cnt   <= cnt + 6'd1;
        end
        ST_END: begin
          state <= IDLE;
          if (cmd_i && (rx_crc == crc)) begin
            cmd_vld <= 1'b1;
            cmd_idx <= f_idx;
            cmd_arg <= f_arg;
            app     <= (f_idx == 6'd55);
            case (f_idx)
              6'd0: begin
                bus_width <= 2'b00;
                adln      <= AW'(BLEN_DEF);
              end
              6'd6: begin
                if (app && !f_arg[0]) bus_width <= f_arg[1:0];
                else                  cmd_ill   <= 1'b1;
              end
              6'd16: begin
                if (len_ok) adln    <= f_arg[AW-1:0];
                else        cmd_ill <= 1'b1;
              end
              6'd17: begin
                if (!busy) begin
                  ldad <= f_arg[AW-1:0];
                  read <= 1'b1;
                end else begin
                  cmd_ill <= 1'b1;
                end
              end
              default: ;
            endcase
          end else begin
            crc_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_slv_cmd_dec.sv
// Directed bench for sd_slv_cmd_dec: frame-level reference model compared every cycle,
// plus literal pins on key results.
module tb_sd_slv_cmd_dec;

  localparam int AW       = 10;
  localparam int BLEN_DEF = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_i;
  logic          busy;
  logic [1:0]    bus_width;
  logic          read;
  logic [AW-1:0] ldad, adln;
  logic [5:0]    cmd_idx;
  logic [31:0]   cmd_arg;
  logic          cmd_vld, crc_err, cmd_ill;

  sd_slv_cmd_dec #(.BLEN_DEF(BLEN_DEF), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cmd_i(cmd_i), .busy(busy),
    .bus_width(bus_width), .read(read), .ldad(ldad), .adln(adln),
    .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .cmd_vld(cmd_vld), .crc_err(crc_err), .cmd_ill(cmd_ill)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [1:0]    e_bw;
  logic [AW-1:0] e_ldad, e_adln;
  logic [5:0]    e_idx;
  logic [31:0]   e_arg;
  logic          e_app, e_read, e_vld, e_err, e_ill;

  int n_cmp = 0;
  int n_err = 0;
  int read_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // CRC7 by polynomial long division of M(x)*x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7_of(input logic [39:0] m);
    logic [46:0] v;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  task automatic model_reset();
    e_bw = 2'b00; e_ldad = '0; e_adln = AW'(BLEN_DEF);
    e_idx = '0; e_arg = '0; e_app = 1'b0;
    e_read = 1'b0; e_vld = 1'b0; e_err = 1'b0; e_ill = 1'b0;
  endtask

  task automatic model_frame(input logic [5:0] idx, input logic [31:0] arg, input logic good);
    if (!good) begin
      e_err = 1'b1;
      return;
    end
    e_vld = 1'b1; e_idx = idx; e_arg = arg;
    if (idx == 6'd0) begin
      e_bw = 2'b00; e_adln = AW'(BLEN_DEF);
    end else if (idx == 6'd6) begin
      if (e_app && arg[1:0] == 2'b00)      e_bw = 2'b00;
      else if (e_app && arg[1:0] == 2'b10) e_bw = 2'b10;
      else                                 e_ill = 1'b1;
    end else if (idx == 6'd16) begin
      if (arg >= 1 && arg < (1 << AW)) e_adln = arg[AW-1:0];
      else                             e_ill = 1'b1;
    end else if (idx == 6'd17) begin
      if (!busy) begin e_ldad = arg[AW-1:0]; e_read = 1'b1; end
      else       e_ill = 1'b1;
    end
    e_app = (idx == 6'd55);
  endtask

  task automatic drive_bit(input logic b);
    cmd_i = b;
    @(posedge clk); #1;
    e_read = 1'b0; e_vld = 1'b0; e_err = 1'b0; e_ill = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_raw(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [6:0] crc, input logic endb);
    logic [47:0] f;
    f = {1'b0, 1'b1, idx, arg, crc, endb};
    for (int i = 47; i >= 0; i--) drive_bit(f[i]);
    model_frame(idx, arg, endb && (crc == crc7_of({1'b0, 1'b1, idx, arg})));
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] arg);
    send_raw(idx, arg, crc7_of({1'b0, 1'b1, idx, arg}), 1'b1);
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("bus_width", 32'(bus_width), 32'(e_bw));
    chk("read",      32'(read),      32'(e_read));
    chk("ldad",      32'(ldad),      32'(e_ldad));
    chk("adln",      32'(adln),      32'(e_adln));
    chk("cmd_idx",   32'(cmd_idx),   32'(e_idx));
    chk("cmd_arg",   cmd_arg,        e_arg);
    chk("cmd_vld",   32'(cmd_vld),   32'(e_vld));
    chk("crc_err",   32'(crc_err),   32'(e_err));
    chk("cmd_ill",   32'(cmd_ill),   32'(e_ill));
    if (read) read_cnt++;
  end

  logic [47:0] part;

  initial begin
    rst = 1'b0; cmd_i = 1'b1; busy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // 1: CMD0 with literal CRC 0x4A
    send_raw(6'd0, 32'd0, 7'h4A, 1'b1);
    chk("t1_vld",  32'(cmd_vld), 32'd1);
    chk("t1_adln", 32'(adln),    32'd512);
    chk("t1_idx",  32'(cmd_idx), 32'd0);
    idle(3);

    // 2: CMD16 then CMD17 back to back
    read_cnt = 0;
    send(6'd16, 32'h40);
    send(6'd17, 32'h123);
    chk("t2_read_with_vld", 32'(read & cmd_vld), 32'd1);
    idle(3);
    chk("t2_adln",  32'(adln), 32'h040);
    chk("t2_ldad",  32'(ldad), 32'h123);
    chk("t2_reads", 32'(read_cnt), 32'd1);

    // 3: CMD55 + ACMD6 -> 4-bit, bare CMD6 illegal
    send(6'd55, 32'd0);
    send(6'd6, 32'h2);
    idle(2);
    chk("t3_bw", 32'(bus_width), 32'h2);
    send(6'd6, 32'h0);
    chk("t3_ill", 32'(cmd_ill), 32'd1);
    idle(2);
    chk("t3_bw_kept", 32'(bus_width), 32'h2);

    // 4: bad CRC, bad end bit
    read_cnt = 0;
    send_raw(6'd17, 32'h55, crc7_of({2'b01, 6'd17, 32'h55}) ^ 7'h04, 1'b1);
    chk("t4_crc_err", 32'(crc_err), 32'd1);
    idle(2);
    send_raw(6'd17, 32'h66, crc7_of({2'b01, 6'd17, 32'h66}), 1'b0);
    chk("t4_end_err", 32'(crc_err), 32'd1);
    idle(2);
    chk("t4_ldad",  32'(ldad), 32'h123);
    chk("t4_reads", 32'(read_cnt), 32'd0);

    // 5: busy read, out-of-range lengths
    busy = 1'b1;
    send(6'd17, 32'h010);
    chk("t5_busy_ill", 32'(cmd_ill & cmd_vld), 32'd1);
    idle(2);
    busy = 1'b0;
    send(6'd16, 32'd0);
    idle(1);
    send(6'd16, 32'h400);
    idle(2);
    chk("t5_adln", 32'(adln), 32'h040);

    // 6: reset mid-frame, then a clean CMD17
    part = {2'b01, 6'd17, 32'h2AA, crc7_of({2'b01, 6'd17, 32'h2AA}), 1'b1};
    for (int i = 47; i > 27; i--) drive_bit(part[i]);
    rst = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b1;
    idle(2);
    read_cnt = 0;
    send(6'd17, 32'h3FF);
    idle(3);
    chk("t6_ldad",  32'(ldad), 32'h3FF);
    chk("t6_reads", 32'(read_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
